// File: rtl/seg_scan_driver.sv
// ============================================================================
//  Module      : seg_scan_driver
//  Description : Multiplexed 4-digit 7-segment driver for a 12-bit result,
//                with signed display, leading-zero blanking and anode blanking.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module seg_scan_driver #(
   parameter int REFRESH_DIV = 50000,
   parameter int BLANK_CYC   = 500,
   parameter int LZ_BLANK    = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [11:0] result,
   input  logic        result_valid,
   input  logic        hold,
   input  logic        signed_mode,
   output logic [3:0]  an,
   output logic [6:0]  seg_n,
   output logic        dp_n,
   output logic        frame_done
);

   localparam logic [15:0] c_last      = 16'(REFRESH_DIV - 1);
   localparam logic [15:0] c_blank     = 16'(BLANK_CYC);
   localparam logic [6:0]  c_seg_blank = 7'h7F;
   localparam logic [6:0]  c_seg_minus = 7'h3F;

   logic [15:0] r_presc;
   logic [1:0]  r_digit;
   logic [11:0] r_pending;
   logic [11:0] r_shadow;
   logic        w_term;
   logic        w_neg;
   logic [11:0] w_mag;
   logic [6:0]  w_seg;

   function automatic logic [6:0] f_hex(input logic [3:0] n);
      case (n)
         4'h0: f_hex = 7'h40;
         4'h1: f_hex = 7'h79;
         4'h2: f_hex = 7'h24;
         4'h3: f_hex = 7'h30;
         4'h4: f_hex = 7'h19;
         4'h5: f_hex = 7'h12;
         4'h6: f_hex = 7'h02;
         4'h7: f_hex = 7'h78;
         4'h8: f_hex = 7'h00;
         4'h9: f_hex = 7'h10;
         4'hA: f_hex = 7'h08;
         4'hB: f_hex = 7'h03;
         4'hC: f_hex = 7'h46;
         4'hD: f_hex = 7'h21;
         4'hE: f_hex = 7'h06;
         default: f_hex = 7'h0E;
      endcase
   endfunction

   assign w_term = (r_presc == c_last);
   assign w_neg  = signed_mode & r_shadow[11];
   // 0x800 negates to itself, which is exactly the "-800" we want to show
   assign w_mag  = w_neg ? (~r_shadow + 12'd1) : r_shadow;
   assign dp_n   = 1'b1;

   always_comb begin
      w_seg = c_seg_blank;
      case (r_digit)
         2'd0: w_seg = f_hex(w_mag[3:0]);
         2'd1: w_seg = ((LZ_BLANK != 0) && (w_mag[11:4] == 8'd0)) ? c_seg_blank : f_hex(w_mag[7:4]);
         2'd2: w_seg = ((LZ_BLANK != 0) && (w_mag[11:8] == 4'd0)) ? c_seg_blank : f_hex(w_mag[11:8]);
         default: w_seg = w_neg ? c_seg_minus : c_seg_blank;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_presc    <= 16'd0;
         r_digit    <= 2'd0;
         r_pending  <= 12'd0;
         r_shadow   <= 12'd0;
         an         <= 4'hF;
         seg_n      <= c_seg_blank;
         frame_done <= 1'b0;
      end else begin
         r_presc <= w_term ? 16'd0 : r_presc + 16'd1;
         if (w_term) begin
            r_digit <= r_digit + 2'd1;
         end
         // Shadow only moves between frames so a frame never shows mixed values
         if (w_term && (r_digit == 2'd3)) begin
            r_shadow <= r_pending;
         end
         if (result_valid && !hold) begin
            r_pending <= result;
         end
         an         <= (r_presc < c_blank) ? 4'hF : ~(4'b0001 << r_digit);
         seg_n      <= w_seg;
         frame_done <= w_term && (r_digit == 2'd3);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
// ============================================================================
//  Module      : tb_seg_scan_driver
//  Description : Self-checking bench for seg_scan_driver (vector table, corner
//                sequences and randomized traffic against a frame-level model).
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_seg_scan_driver;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [11:0] result;
   logic        result_valid;
   logic        hold;
   logic        signed_mode;
   logic [3:0]  an;
   logic [6:0]  seg_n;
   logic        dp_n;
   logic        frame_done;

   always #5 clk = ~clk;

   seg_scan_driver #(
      .REFRESH_DIV(4),
      .BLANK_CYC  (1),
      .LZ_BLANK   (1)
   ) u_dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .result      (result),
      .result_valid(result_valid),
      .hold        (hold),
      .signed_mode (signed_mode),
      .an          (an),
      .seg_n       (seg_n),
      .dp_n        (dp_n),
      .frame_done  (frame_done)
   );

   int total = 0;
   int bad   = 0;

   logic [6:0] enc    [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   logic [3:0] an_tab [0:3]  = '{4'hE, 4'hD, 4'hB, 4'h7};

   // Model state: cycles elapsed since reset, pending word, frame word
   int          m_s;
   logic [11:0] m_pend;
   logic [11:0] m_shad;
   logic [6:0]  got [0:3];

   typedef struct {
      logic [11:0] val;
      logic        sm;
      logic [6:0]  e0, e1, e2, e3;
   } vec_t;
   vec_t vecs [0:7];

   function automatic logic [6:0] exp_seg(input int dg, input logic [11:0] shad, input logic sm);
      int v;
      int mag;
      bit neg;
      v   = int'(shad);
      neg = sm && (v >= 2048);
      mag = neg ? 4096 - v : v;
      case (dg)
         0:       return enc[mag % 16];
         1:       return (mag < 16)  ? 7'h7F : enc[(mag / 16) % 16];
         2:       return (mag < 256) ? 7'h7F : enc[mag / 256];
         default: return neg ? 7'h3F : 7'h7F;
      endcase
   endfunction

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: predict outputs from the model, clock, then compare.
   task automatic tick();
      logic [3:0] ea;
      logic [6:0] es;
      logic       ef;
      int         dg;
      int         ph;
      dg = 0;
      ph = -1;
      if (!reset_n) begin
         ea = 4'hF; es = 7'h7F; ef = 1'b0;
         m_s = 0; m_pend = 12'd0; m_shad = 12'd0;
      end else begin
         ph = m_s % 4;
         dg = (m_s / 4) % 4;
         ea = (ph < 1) ? 4'hF : an_tab[dg];
         es = exp_seg(dg, m_shad, signed_mode);
         ef = ((m_s % 16) == 15);
         if ((m_s % 16) == 15) m_shad = m_pend;
         if (result_valid && !hold) m_pend = result;
         m_s++;
      end
      @(posedge clk);
      #1;
      check("an", int'(an), int'(ea));
      check("seg_n", int'(seg_n), int'(es));
      check("frame_done", int'(frame_done), int'(ef));
      check("dp_n", int'(dp_n), 1);
      if (ph == 2) got[dg] = seg_n;
   endtask

   // Strobe a value, run to the frame that displays it, check all four digits.
   task automatic show_frame(input logic [11:0] val, input logic sm,
                             input logic [6:0] e0, input logic [6:0] e1,
                             input logic [6:0] e2, input logic [6:0] e3,
                             input string nm);
      signed_mode  = sm;
      result       = val;
      result_valid = 1'b1;
      tick();
      result_valid = 1'b0;
      do tick(); while ((m_s % 16) != 0);
      repeat (16) tick();
      check({nm, ".d0"}, int'(got[0]), int'(e0));
      check({nm, ".d1"}, int'(got[1]), int'(e1));
      check({nm, ".d2"}, int'(got[2]), int'(e2));
      check({nm, ".d3"}, int'(got[3]), int'(e3));
   endtask

   logic [3:0] an_seq [0:15] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                                 4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};

   initial begin
      vecs[0] = '{12'hA5C, 1'b0, 7'h46, 7'h12, 7'h08, 7'h7F};
      vecs[1] = '{12'hFFF, 1'b1, 7'h79, 7'h7F, 7'h7F, 7'h3F};
      vecs[2] = '{12'h800, 1'b1, 7'h40, 7'h40, 7'h00, 7'h3F};
      vecs[3] = '{12'h07F, 1'b1, 7'h0E, 7'h78, 7'h7F, 7'h7F};
      vecs[4] = '{12'hFFF, 1'b0, 7'h0E, 7'h0E, 7'h0E, 7'h7F};
      vecs[5] = '{12'h010, 1'b0, 7'h40, 7'h79, 7'h7F, 7'h7F};
      vecs[6] = '{12'h100, 1'b0, 7'h40, 7'h40, 7'h79, 7'h7F};
      vecs[7] = '{12'h000, 1'b1, 7'h40, 7'h7F, 7'h7F, 7'h7F};

      reset_n = 1'b0; result = 12'd0; result_valid = 1'b0; hold = 1'b0; signed_mode = 1'b0;
      m_s = 0; m_pend = 12'd0; m_shad = 12'd0;
      for (int i = 0; i < 4; i++) got[i] = 7'h7F;
      tick();
      tick();
      reset_n = 1'b1;

      // First frame after reset, against the literal anode sequence
      for (int i = 0; i < 16; i++) begin
         tick();
         check("reset_an_seq", int'(an), int'(an_seq[i]));
      end
      check("first_frame_done", int'(frame_done), 1);
      check("first_frame.d0", int'(got[0]), 8'h40);
      check("first_frame.d1", int'(got[1]), 8'h7F);

      // Strobe lands mid-frame
      repeat (6) tick();
      for (int i = 0; i < 8; i++)
         show_frame(vecs[i].val, vecs[i].sm, vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].e3, "vec");

      // Hold freezes capture
      show_frame(12'h123, 1'b0, 7'h30, 7'h24, 7'h79, 7'h7F, "hold_pre");
      hold = 1'b1;
      show_frame(12'h456, 1'b0, 7'h30, 7'h24, 7'h79, 7'h7F, "hold_on");
      hold = 1'b0;
      show_frame(12'h456, 1'b0, 7'h02, 7'h12, 7'h19, 7'h7F, "hold_off");

      // Reset during digit 2 with a simultaneous strobe
      for (int i = 0; i < 16 && !(((m_s / 4) % 4 == 2) && (m_s % 4 == 1)); i++) tick();
      reset_n = 1'b0; result_valid = 1'b1; result = 12'h777;
      tick();
      check("midreset_an", int'(an), 4'hF);
      check("midreset_seg", int'(seg_n), 8'h7F);
      reset_n = 1'b1; result_valid = 1'b0;
      repeat (32) tick();
      check("after_reset.d0", int'(got[0]), 8'h40);
      check("after_reset.d3", int'(got[3]), 8'h7F);

      // Randomized traffic against the model
      repeat (600) begin
         result       = 12'($urandom);
         result_valid = ($urandom % 6) == 0;
         hold         = ($urandom % 4) == 0;
         signed_mode  = 1'($urandom % 2);
         reset_n      = ($urandom % 150) != 0;
         tick();
      end
      reset_n = 1'b1;
      result_valid = 1'b0;
      hold = 1'b0;
      repeat (20) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
